batalha_naval_ctrl: RTL and testbench
=====================================

BATALHA_NAVAL_CTRL -- requirements
Module: batalha_naval_ctrl

Interface
REQ-001 Parameter MAX_SHOTS, default 8, shots allowed per player per game (1..8).
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  begin new game; sampled in IDLE or DONE only.
REQ-005 p1_valid  in  1  player 1 presents placement or shot on p1_pos.
REQ-006 p1_pos  in  3  player 1 cell (0..7).
REQ-007 p2_valid  in  1  player 2 presents placement or shot on p2_pos.
REQ-008 p2_pos  in  3  player 2 cell (0..7).
REQ-009 p1_ready  out  1  controller accepts p1 transfer this cycle.
REQ-010 p2_ready  out  1  controller accepts p2 transfer this cycle.
REQ-011 hit  out  1  one-cycle pulse: last accepted shot equals opponent ship cell.
REQ-012 miss  out  1  one-cycle pulse: last accepted shot differs from opponent ship cell.
REQ-013 reject  out  1  one-cycle pulse: shot refused (see Configuration); constant 0 when feature absent.
REQ-014 winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw; valid in DONE.
REQ-015 state_o  out  3  current FSM state encoding.
REQ-016 shots1, shots2  out  4 each  accepted-shot counters per player.

Function
REQ-017 States SHALL be IDLE, PLACE1, PLACE2, TURN1, TURN2, DONE.
REQ-018 IDLE/DONE + start -> PLACE1; counters, winner, stored ships cleared on same edge.
REQ-019 Transfer accepted when valid & ready on a rising edge; ready asserted only for the player owning the current state (p1: PLACE1, TURN1; p2: PLACE2, TURN2), combinationally from state.
REQ-020 PLACE1 accept -> store ship1 = p1_pos, go PLACE2; PLACE2 accept -> store ship2 = p2_pos, go TURN1.
REQ-021 TURN1 accept -> compare p1_pos with ship2 (all 3 bits equal = hit), shots1 += 1; TURN2 symmetric with ship1, shots2 += 1.
REQ-022 hit/miss SHALL pulse exactly one cycle, the cycle after acceptance (1-cycle latency); never both high.
REQ-023 Hit by player N -> DONE, winner = N, on the acceptance edge.
REQ-024 Miss in TURN1 -> TURN2; miss in TURN2 with shots2 reaching MAX_SHOTS -> DONE, winner = 11; otherwise -> TURN1.
REQ-025 Valid from the non-owning player SHALL be ignored with no side effect, including when both valids are high simultaneously.
REQ-026 start outside IDLE/DONE SHALL be ignored.
REQ-027 Counters SHALL saturate at MAX_SHOTS; no wrap.

Reset
REQ-028 rst_n low at a rising edge SHALL force IDLE, winner 00, shots1/shots2 0, ships 0, hit/miss/reject 0, history cleared, regardless of state (mid-game included).
REQ-029 Outputs p1_ready/p2_ready SHALL be 0 while in IDLE after reset.

Configuration
REQ-030 Macro BATALHA_SHOT_HISTORY_EN defined: per-player 8-bit fired-cell map; accepted shot on an already-fired cell SHALL pulse reject one cycle later, not count, not compare, not change turn; map cleared on start.
REQ-031 Macro undefined: no history storage, reject tied to 0, repeated cells treated as normal shots.

Structure
REQ-032 Shared package batalha_pkg SHALL hold the state enum, winner codes (WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW) and position width constant (3).
REQ-033 One sub-module batalha_cmp SHALL perform the 3-bit position equality (hit) compare; instantiated once, inputs muxed by turn.

Verification
REQ-034 start, p1 place 5, p2 place 2, p1 shoots 2 -> hit pulse next cycle, DONE, winner 01, shots1 1.
REQ-035 place 3/4, p1 shoots 0 (miss), p2 shoots 3 -> miss then hit, winner 10, shots1 1, shots2 1.
REQ-036 MAX_SHOTS 2, place 7/7, all shots 0 -> four miss pulses, DONE, winner 11, shots 2/2.
REQ-037 TURN1 with p1_valid and p2_valid both high, p2_pos = ship1 -> only p1 shot processed, no p2 hit.
REQ-038 rst_n low for one edge while in TURN2 -> IDLE, all outputs zero next cycle; start ignored during TURN1.
REQ-039 With BATALHA_SHOT_HISTORY_EN: p1 shoots 1, p2 shoots 6, p1 shoots 1 again -> reject pulse, shots1 stays 1, state stays TURN1.

Source files
------------

// File: rtl/batalha_pkg.sv
// Shared types and constants for the batalha naval (battleship) game controller.
package batalha_pkg;

    localparam int POS_W = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLACE1 = 3'd1,
        PLACE2 = 3'd2,
        TURN1  = 3'd3,
        TURN2  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Counter increment that holds at the limit instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/batalha_cmp.sv
// Position equality compare used to decide whether a shot lands on the opponent ship.
module batalha_cmp
    import batalha_pkg::*;
(
    input  logic [POS_W-1:0] shot,
    input  logic [POS_W-1:0] ship,
    output logic             eq
);

    assign eq = (shot == ship);

endmodule

// File: rtl/batalha_naval_ctrl.sv
// Two-player one-ship battleship controller: placement, alternating shots, winner decision.
// Optional macro BATALHA_SHOT_HISTORY_EN adds per-player fired-cell maps that reject repeated shots.
module batalha_naval_ctrl
    import batalha_pkg::*;
#(
    parameter int MAX_SHOTS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             p1_valid,
    input  logic [POS_W-1:0] p1_pos,
    input  logic             p2_valid,
    input  logic [POS_W-1:0] p2_pos,
    output logic             p1_ready,
    output logic             p2_ready,
    output logic             hit,
    output logic             miss,
    output logic             reject,
    output logic [1:0]       winner,
    output logic [2:0]       state_o,
    output logic [3:0]       shots1,
    output logic [3:0]       shots2
);

    localparam logic [3:0] MAX_S = 4'(MAX_SHOTS);

    state_t           state;
    logic [POS_W-1:0] ship1;
    logic [POS_W-1:0] ship2;
    logic [POS_W-1:0] cmp_shot;
    logic [POS_W-1:0] cmp_ship;
    logic             is_hit;
    logic             shot_ok;
    logic             new_game;

    assign p1_ready = (state == PLACE1) || (state == TURN1);
    assign p2_ready = (state == PLACE2) || (state == TURN2);
    assign state_o  = state;
    assign new_game = ((state == IDLE) || (state == DONE)) && start;

    // Single comparator: the shooter's cell against the opponent's ship.
    assign cmp_shot = (state == TURN1) ? p1_pos : p2_pos;
    assign cmp_ship = (state == TURN1) ? ship2  : ship1;

    batalha_cmp u_cmp (
        .shot (cmp_shot),
        .ship (cmp_ship),
        .eq   (is_hit)
    );

`ifdef BATALHA_SHOT_HISTORY_EN
    logic [7:0] fired1;
    logic [7:0] fired2;
    logic       reject_q;

    assign shot_ok = (state == TURN1) ? !fired1[p1_pos] : !fired2[p2_pos];
    assign reject  = reject_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fired1   <= 8'd0;
            fired2   <= 8'd0;
            reject_q <= 1'b0;
        end else begin
            reject_q <= 1'b0;
            if (new_game) begin
                fired1 <= 8'd0;
                fired2 <= 8'd0;
            end else if (state == TURN1 && p1_valid) begin
                if (fired1[p1_pos]) reject_q <= 1'b1;
                else                fired1[p1_pos] <= 1'b1;
            end else if (state == TURN2 && p2_valid) begin
                if (fired2[p2_pos]) reject_q <= 1'b1;
                else                fired2[p2_pos] <= 1'b1;
            end
        end
    end
`else
    assign shot_ok = 1'b1;
    assign reject  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ship1  <= '0;
            ship2  <= '0;
            shots1 <= 4'd0;
            shots2 <= 4'd0;
            winner <= WIN_NONE;
            hit    <= 1'b0;
            miss   <= 1'b0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (new_game) begin
                        state  <= PLACE1;
                        ship1  <= '0;
                        ship2  <= '0;
                        shots1 <= 4'd0;
                        shots2 <= 4'd0;
                        winner <= WIN_NONE;
                    end
                end
                PLACE1: begin
                    if (p1_valid) begin
                        ship1 <= p1_pos;
                        state <= PLACE2;
                    end
                end
                PLACE2: begin
                    if (p2_valid) begin
                        ship2 <= p2_pos;
                        state <= TURN1;
                    end
                end
                TURN1: begin
                    if (p1_valid && shot_ok) begin
                        shots1 <= sat_inc(shots1, MAX_S);
                        if (is_hit) begin
                            hit    <= 1'b1;
                            winner <= WIN_P1;
                            state  <= DONE;
                        end else begin
                            miss  <= 1'b1;
                            state <= TURN2;
                        end
                    end
                end
                TURN2: begin
                    if (p2_valid && shot_ok) begin
                        shots2 <= sat_inc(shots2, MAX_S);
                        if (is_hit) begin
                            hit    <= 1'b1;
                            winner <= WIN_P2;
                            state  <= DONE;
                        end else begin
                            miss <= 1'b1;
                            // Player 2 closes each round, so its last miss ends the game.
                            if (sat_inc(shots2, MAX_S) == MAX_S) begin
                                winner <= WIN_DRAW;
                                state  <= DONE;
                            end else begin
                                state <= TURN1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_batalha_naval_ctrl.sv
// Self-checking bench for batalha_naval_ctrl: directed game scenarios then randomized play
// against a game-rule reference model. Honours BATALHA_SHOT_HISTORY_EN when defined.
module tb_batalha_naval_ctrl;
   import batalha_pkg::*;

   localparam int MAX = 2;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       p1_valid;
   logic [2:0] p1_pos;
   logic       p2_valid;
   logic [2:0] p2_pos;
   logic       p1_ready;
   logic       p2_ready;
   logic       hit;
   logic       miss;
   logic       reject;
   logic [1:0] winner;
   logic [2:0] state_o;
   logic [3:0] shots1;
   logic [3:0] shots2;

   int checks;
   int failures;

   // Reference model of the game, advanced once per rising edge.
   state_t m_state;
   int     m_ship[2];
   int     m_shots[2];
   bit     m_fired[2][8];
   logic [1:0] m_winner;
   bit     m_hit;
   bit     m_miss;
   bit     m_reject;

   batalha_naval_ctrl #(.MAX_SHOTS(MAX)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .p1_valid (p1_valid),
      .p1_pos   (p1_pos),
      .p2_valid (p2_valid),
      .p2_pos   (p2_pos),
      .p1_ready (p1_ready),
      .p2_ready (p2_ready),
      .hit      (hit),
      .miss     (miss),
      .reject   (reject),
      .winner   (winner),
      .state_o  (state_o),
      .shots1   (shots1),
      .shots2   (shots2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic bit historyEnabled();
`ifdef BATALHA_SHOT_HISTORY_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Resolve one shot by player p (0 or 1) at cell pos according to the game rules.
   task automatic modelShot(input int p, input int pos);
      if (historyEnabled() && m_fired[p][pos]) begin
         m_reject = 1'b1;
         return;
      end
      m_fired[p][pos] = 1'b1;
      if (m_shots[p] < MAX) m_shots[p]++;
      if (pos == m_ship[1 - p]) begin
         m_hit    = 1'b1;
         m_winner = (p == 0) ? WIN_P1 : WIN_P2;
         m_state  = DONE;
      end else begin
         m_miss = 1'b1;
         if (p == 0)                m_state = TURN2;
         else if (m_shots[1] == MAX) begin
            m_winner = WIN_DRAW;
            m_state  = DONE;
         end else                   m_state = TURN1;
      end
   endtask

   task automatic clearGame();
      m_ship   = '{0, 0};
      m_shots  = '{0, 0};
      m_winner = WIN_NONE;
      for (int p = 0; p < 2; p++)
         for (int c = 0; c < 8; c++) m_fired[p][c] = 1'b0;
   endtask

   task automatic modelStep();
      m_hit    = 1'b0;
      m_miss   = 1'b0;
      m_reject = 1'b0;
      if (!rst_n) begin
         clearGame();
         m_state = IDLE;
         return;
      end
      case (m_state)
         IDLE, DONE: if (start) begin clearGame(); m_state = PLACE1; end
         PLACE1: if (p1_valid) begin m_ship[0] = int'(p1_pos); m_state = PLACE2; end
         PLACE2: if (p2_valid) begin m_ship[1] = int'(p2_pos); m_state = TURN1; end
         TURN1:  if (p1_valid) modelShot(0, int'(p1_pos));
         TURN2:  if (p2_valid) modelShot(1, int'(p2_pos));
         default: m_state = IDLE;
      endcase
   endtask

   task automatic checkOutput(input string tag);
      check({tag, ".state"},    8'(state_o),  8'(m_state));
      check({tag, ".winner"},   8'(winner),   8'(m_winner));
      check({tag, ".shots1"},   8'(shots1),   8'(m_shots[0]));
      check({tag, ".shots2"},   8'(shots2),   8'(m_shots[1]));
      check({tag, ".hit"},      8'(hit),      8'(m_hit));
      check({tag, ".miss"},     8'(miss),     8'(m_miss));
      check({tag, ".reject"},   8'(reject),   8'(m_reject));
      check({tag, ".p1_ready"}, 8'(p1_ready), 8'(m_state == PLACE1 || m_state == TURN1));
      check({tag, ".p2_ready"}, 8'(p2_ready), 8'(m_state == PLACE2 || m_state == TURN2));
   endtask

   // Drive one cycle of inputs, advance model on the edge, compare just after it.
   task automatic applyStimulus(input string tag, input logic rst_v, input logic st,
                                input logic v1, input logic [2:0] pos1,
                                input logic v2, input logic [2:0] pos2);
      rst_n    = rst_v;
      start    = st;
      p1_valid = v1;
      p1_pos   = pos1;
      p2_valid = v2;
      p2_pos   = pos2;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput(tag);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      m_state  = IDLE;
      clearGame();
      rst_n = 1'b0; start = 1'b0; p1_valid = 1'b0; p1_pos = 3'd0; p2_valid = 1'b0; p2_pos = 3'd0;

      $display("[TB] reset");
      applyStimulus("reset0", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      applyStimulus("reset1", 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 3'd0);
      applyStimulus("idle",   1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3);
      check("idle_state_const", 8'(state_o), 8'(IDLE));

      $display("[TB] player 1 hits first shot");
      applyStimulus("g1.start",  1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
      applyStimulus("g1.place1", 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 3'd0);
      applyStimulus("g1.place2", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd2);
      applyStimulus("g1.shot",   1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0);
      check("g1.hit_const",    8'(hit),    8'd1);
      check("g1.winner_const", 8'(winner), 8'(WIN_P1));
      check("g1.shots1_const", 8'(shots1), 8'd1);
      applyStimulus("g1.after",  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);

      $display("[TB] player 2 wins after a miss");
      applyStimulus("g2.start",  1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
      applyStimulus("g2.place1", 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0);
      applyStimulus("g2.place2", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd4);
      applyStimulus("g2.shot1",  1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0);
      check("g2.miss_const", 8'(miss), 8'd1);
      applyStimulus("g2.shot2",  1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd3);
      check("g2.winner_const", 8'(winner), 8'(WIN_P2));
      check("g2.shots_const",  8'({shots1, shots2}), 8'h11);

      $display("[TB] draw at shot limit");
      applyStimulus("g3.start",  1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
      applyStimulus("g3.place1", 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 3'd0);
      applyStimulus("g3.place2", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd7);
      for (int i = 0; i < 2; i++) begin
         applyStimulus("g3.p1", 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0);
         applyStimulus("g3.p2", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0);
      end
      check("g3.winner_const", 8'(winner), 8'(WIN_DRAW));
      check("g3.shots_const",  8'({shots1, shots2}), 8'h22);

      $display("[TB] both valids, start ignored mid-game, reset mid-game");
      applyStimulus("g4.start",  1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
      applyStimulus("g4.place1", 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 3'd0);
      applyStimulus("g4.place2", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1);
      applyStimulus("g4.nostart",1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
      applyStimulus("g4.both",   1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 3'd6);
      check("g4.no_hit_const", 8'(hit), 8'd0);
      applyStimulus("g4.rst",    1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      check("g4.rst_state_const", 8'(state_o), 8'(IDLE));

`ifdef BATALHA_SHOT_HISTORY_EN
      $display("[TB] repeated shot rejected");
      applyStimulus("g5.start",  1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
      applyStimulus("g5.place1", 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 3'd0);
      applyStimulus("g5.place2", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd5);
      applyStimulus("g5.p1a",    1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 3'd0);
      applyStimulus("g5.p2",     1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd6);
      applyStimulus("g5.p1b",    1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 3'd0);
      check("g5.reject_const", 8'(reject), 8'd1);
      check("g5.shots1_const", 8'(shots1), 8'd1);
`endif

      $display("[TB] randomized play");
      for (int i = 0; i < 400; i++) begin
         applyStimulus("rand",
                       logic'($urandom_range(0, 59) != 0),
                       logic'($urandom_range(0, 3) == 0),
                       logic'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                       logic'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
